// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_e     : controller states (IDLE, BUSY, DONE)
//   MODE_ADD/SUB: encoding of the in_mode operation select
//   clog2()     : counter width helper, never returns less than 1
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Counter width for n digits; a single-digit build still gets a 1-bit counter.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/seq_addsub_if.sv
// Operand/result handshake bundle for seq_addsub.
//   in_valid/in_ready   : operand transfer (in_a, in_b, in_mode)
//   out_valid/out_ready : result transfer (out_result + flags)
//   master = producer/consumer side, slave = the arithmetic block.
interface seq_addsub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_overflow;
    logic             out_carry;
    logic             out_zero;
    logic             out_negative;

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_result,
               out_overflow, out_carry, out_zero, out_negative
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_result,
               out_overflow, out_carry, out_zero, out_negative
    );
endinterface

// File: rtl/seq_addsub_digit.sv
// Combinational DIGIT-bit adder slice.
//   a, b  : digit operands
//   cin   : carry into bit 0
//   sum   : digit sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (for signed overflow detection)
module addsub_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    localparam int unsigned SW = DIGIT + 1;

    logic [DIGIT:0] full_c;

    assign full_c = {1'b0, a} + {1'b0, b} + SW'(cin);
    assign sum    = full_c[DIGIT-1:0];
    assign cout   = full_c[DIGIT];
    // Top sum bit is a^b^carry_in, so the carry into it falls out by XOR.
    assign c_msb  = full_c[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
endmodule

// File: rtl/seq_addsub.sv
// Digit-serial two's-complement adder/subtractor.
// Adds DIGIT bits per clock, LSB first; result valid WIDTH/DIGIT cycles
// after the operand handshake, held in DONE until out_ready.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : seq_addsub_if.slave (operand and result handshakes)
// Build option:
//   SEQ_ADDSUB_SAT_EN : saturate the result on signed overflow
module seq_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_addsub_if.slave  bus
);
    localparam int unsigned NDIG  = WIDTH / DIGIT;
    localparam int unsigned CNT_W = clog2(NDIG);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] BUSY = ST_BUSY;
    localparam logic [1:0] DONE = ST_DONE;

    // Reject illegal geometry at elaboration.
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("seq_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             cy_q;

    logic             accept_c, step_c, last_c;
    logic [DIGIT-1:0] sum_c;
    logic             cout_c, msb_c, ovf_c;
    logic [WIDTH-1:0] res_d, fin_c;

`ifdef SEQ_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic a_msb_q;
`endif

    // One slice, fed from the low digit of the shifting operand registers.
    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .cin   (cy_q),
        .sum   (sum_c),
        .cout  (cout_c),
        .c_msb (msb_c)
    );

    // State register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus.in_ready  <= (state_d == IDLE);
            bus.out_valid <= (state_d == DONE);
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        step_c   = 1'b0;
        last_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_c = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                step_c = 1'b1;
                if (cnt_q == CNT_W'(NDIG - 1)) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // New digit enters at the top; after NDIG steps digit 0 sits at the bottom.
    always_comb begin
        res_d = (res_q >> DIGIT) | (WIDTH'(sum_c) << (WIDTH - DIGIT));
        ovf_c = msb_c ^ cout_c;
        fin_c = res_d;
`ifdef SEQ_ADDSUB_SAT_EN
        if (ovf_c) fin_c = a_msb_q ? SAT_NEG : SAT_POS;
`endif
    end

    // Operand shifters, carry, digit counter and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q              <= '0;
            b_q              <= '0;
            res_q            <= '0;
            cy_q             <= 1'b0;
            cnt_q            <= '0;
            bus.out_result   <= '0;
            bus.out_overflow <= 1'b0;
            bus.out_carry    <= 1'b0;
            bus.out_zero     <= 1'b0;
            bus.out_negative <= 1'b0;
`ifdef SEQ_ADDSUB_SAT_EN
            a_msb_q          <= 1'b0;
`endif
        end else if (accept_c) begin
            // Subtract as A + ~B + 1: the +1 rides in on the initial carry.
            a_q   <= bus.in_a;
            b_q   <= (bus.in_mode == MODE_SUB) ? ~bus.in_b : bus.in_b;
            cy_q  <= bus.in_mode;
            cnt_q <= '0;
            res_q <= '0;
`ifdef SEQ_ADDSUB_SAT_EN
            a_msb_q <= bus.in_a[WIDTH-1];
`endif
        end else if (step_c) begin
            a_q   <= a_q >> DIGIT;
            b_q   <= b_q >> DIGIT;
            cy_q  <= cout_c;
            res_q <= res_d;
            cnt_q <= last_c ? '0 : cnt_q + CNT_W'(1);
            if (last_c) begin
                bus.out_result   <= fin_c;
                bus.out_overflow <= ovf_c;
                bus.out_carry    <= cout_c;
                bus.out_zero     <= ~|fin_c;
                bus.out_negative <= fin_c[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub: a DIGIT=4 instance (4-cycle BUSY)
// and a DIGIT=16 instance (1-cycle BUSY), compared against a signed/unsigned
// integer arithmetic model.
module tb_seq_addsub;
    localparam int unsigned W = 16;

    typedef struct packed {
        logic         rdy;
        logic         vld;
        logic [W-1:0] res;
        logic         ovf;
        logic         cy;
        logic         z;
        logic         n;
    } obs_t;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
        logic         cy;
        logic         z;
        logic         n;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seq_addsub_if #(.WIDTH(W)) b0 ();
    seq_addsub_if #(.WIDTH(W)) b1 ();

    seq_addsub #(.WIDTH(W), .DIGIT(4))  dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    seq_addsub #(.WIDTH(W), .DIGIT(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    // Integer-level reference: true signed result, range test, unsigned compare.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        exp_t   e;
        int     sa, sb, full;
        longint ua, ub;
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        ua   = longint'(a);
        ub   = longint'(b);
        full = m ? (sa - sb) : (sa + sb);
        e.ovf = (full > 32767) || (full < -32768);
        e.cy  = m ? (ua >= ub) : ((ua + ub) > 65535);
        e.res = W'(full);
`ifdef SEQ_ADDSUB_SAT_EN
        if (e.ovf) e.res = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        e.z = (e.res == '0);
        e.n = e.res[W-1];
        return e;
    endfunction

    function automatic obs_t sample(input bit sel);
        obs_t o;
        if (sel) begin
            o.rdy = b1.in_ready;  o.vld = b1.out_valid; o.res = b1.out_result;
            o.ovf = b1.out_overflow; o.cy = b1.out_carry;
            o.z = b1.out_zero; o.n = b1.out_negative;
        end else begin
            o.rdy = b0.in_ready;  o.vld = b0.out_valid; o.res = b0.out_result;
            o.ovf = b0.out_overflow; o.cy = b0.out_carry;
            o.z = b0.out_zero; o.n = b0.out_negative;
        end
        return o;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic m);
        if (sel) begin
            b1.in_valid = v; b1.in_a = a; b1.in_b = b; b1.in_mode = m;
        end else begin
            b0.in_valid = v; b0.in_a = a; b0.in_b = b; b0.in_mode = m;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input obs_t o, input exp_t e);
        check({tag, " out_valid"}, 32'(o.vld), 32'd1);
        check({tag, " in_ready"},  32'(o.rdy), 32'd0);
        check({tag, " result"},    32'(o.res), 32'(e.res));
        check({tag, " overflow"},  32'(o.ovf), 32'(e.ovf));
        check({tag, " carry"},     32'(o.cy),  32'(e.cy));
        check({tag, " zero"},      32'(o.z),   32'(e.z));
        check({tag, " negative"},  32'(o.n),   32'(e.n));
    endtask

    // Call at a falling edge; returns at the falling edge where out_valid is first seen.
    task automatic run_op(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic m, input string tag, output int waited);
        exp_t e;
        obs_t o;
        int   lat;
        e = model(a, b, m);
        drive(sel, 1'b1, a, b, m);
        waited = 0;
        o = sample(sel);
        while (!o.rdy && waited < 64) begin
            @(negedge clk);
            waited++;
            o = sample(sel);
        end
        check({tag, " accept"}, 32'(o.rdy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Garbage on the operand inputs while busy must be ignored.
        drive(sel, 1'b0, W'($urandom), W'($urandom), 1'($urandom));
        lat = 0;
        o = sample(sel);
        while (!o.vld && lat < 64) begin
            @(negedge clk);
            lat++;
            o = sample(sel);
        end
        check({tag, " latency"}, 32'(lat), sel ? 32'd1 : 32'd4);
        check_out(tag, o, e);
    endtask

    initial begin
        obs_t o, hold;
        int   w;
        logic [W-1:0] ra, rb;
        logic rm;
        bit   rs;

        b0.out_ready = 1'b1;
        b1.out_ready = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);

        // Reset state.
        #12;
        o = sample(1'b0);
        check("rst0 in_ready",  32'(o.rdy), 32'd1);
        check("rst0 out_valid", 32'(o.vld), 32'd0);
        check("rst0 outputs",   32'({o.res, o.ovf, o.cy, o.z, o.n}), 32'd0);
        o = sample(1'b1);
        check("rst1 in_ready",  32'(o.rdy), 32'd1);
        check("rst1 out_valid", 32'(o.vld), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed boundary cases on both geometries.
        for (int s = 0; s < 2; s++) begin
            run_op(1'(s), 16'h7FFF, 16'h0001, 1'b0, "add 7fff+1",    w); @(negedge clk);
            run_op(1'(s), 16'h8000, 16'h0001, 1'b1, "sub 8000-1",    w); @(negedge clk);
            run_op(1'(s), 16'h0003, 16'h0005, 1'b1, "sub 3-5",       w); @(negedge clk);
            run_op(1'(s), 16'h1234, 16'h1234, 1'b1, "sub equal",     w); @(negedge clk);
            run_op(1'(s), 16'hFFFF, 16'h0001, 1'b0, "add ffff+1",    w); @(negedge clk);
            run_op(1'(s), 16'h0005, 16'h0003, 1'b0, "add 5+3",       w); @(negedge clk);
            run_op(1'(s), 16'h8000, 16'h8000, 1'b0, "add 8000+8000", w); @(negedge clk);
        end

        // Backpressure: result held, new request refused until release.
        b0.out_ready = 1'b0;
        run_op(1'b0, 16'h1111, 16'h2222, 1'b0, "bp first", w);
        hold = sample(1'b0);
        drive(1'b0, 1'b1, 16'h0F0F, 16'h0101, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            o = sample(1'b0);
            check("bp stable", 32'(o), 32'(hold));
        end
        b0.out_ready = 1'b1;
        @(negedge clk);
        o = sample(1'b0);
        check("bp release out_valid", 32'(o.vld), 32'd0);
        check("bp release in_ready",  32'(o.rdy), 32'd1);
        run_op(1'b0, 16'h0F0F, 16'h0101, 1'b1, "bp second", w);
        check("bp accept wait", 32'(w), 32'd0);
        @(negedge clk);

        // Reset in the middle of an operation (counter at 2).
        drive(1'b0, 1'b1, 16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        o = sample(1'b0);
        check("midrst out_valid", 32'(o.vld), 32'd0);
        check("midrst in_ready",  32'(o.rdy), 32'd1);
        check("midrst outputs",   32'({o.res, o.ovf, o.cy, o.z, o.n}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 16'h0005, 16'h0003, 1'b0, "post-rst 5+3", w);
        @(negedge clk);

        // Random operations across both instances.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rm = 1'($urandom);
            rs = 1'($urandom_range(0, 1));
            run_op(rs, ra, rb, rm, "random", w);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
